// File: rtl/paralelo_serie_tx.sv
// Parallel-to-serial PHY transmitter: one byte per 8 clk_8f cycles, MSB first, 0xBC comma when idle.
// Define PS_TX_SYNC_EN to send SYNC_BYTES commas after reset before the first byte slot opens.
`timescale 1ns/1ps

module paralelo_serie_tx #(
    parameter int SYNC_BYTES = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       frame_out,
    output logic       active_out
);

    localparam logic [7:0] COMMA     = 8'hBC;
    localparam logic [0:0] ST_SYNC   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;
    // An illegal SYNC_BYTES of zero keeps the byte slot permanently closed
    localparam logic       CFG_OK    = (SYNC_BYTES >= 32'sd1);

    logic [2:0] cnt_r;
    logic [7:0] shreg_r;
    logic [0:0] st_r;
    logic       wrap_s;
    logic       take_s;

    // Byte-slot handshake and serial framing decode
    always_comb begin
        wrap_s    = (cnt_r == 3'd7);
        ready_out = wrap_s && (st_r == ST_ACTIVE) && CFG_OK;
        take_s    = ready_out && valid_in;
        frame_out = (cnt_r == 3'd0);
        data_out  = shreg_r[7];
    end

    // Bit counter, shift register and data/comma flag
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            cnt_r      <= 3'd0;
            shreg_r    <= COMMA;
            active_out <= 1'b0;
        end else begin
            cnt_r <= cnt_r + 3'd1;
            if (wrap_s) begin
                if (take_s) begin
                    shreg_r    <= data_in;
                    active_out <= 1'b1;
                end else begin
                    shreg_r    <= COMMA;
                    active_out <= 1'b0;
                end
            end else begin
                shreg_r <= {shreg_r[6:0], 1'b0};
            end
        end
    end

`ifdef PS_TX_SYNC_EN
    localparam int SCW = (SYNC_BYTES > 1) ? $clog2(SYNC_BYTES) : 1;
    localparam logic [SCW-1:0] SYNC_LAST = SCW'(SYNC_BYTES - 1);

    logic [SCW-1:0] sync_cnt_r;

    // Leave SYNC one edge before the last comma's cnt==7 cycle so ready lands on it
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            st_r       <= ST_SYNC;
            sync_cnt_r <= {SCW{1'b0}};
        end else begin
            case (st_r)
                ST_SYNC: begin
                    if (wrap_s) begin
                        sync_cnt_r <= sync_cnt_r + SCW'(1);
                    end else begin
                        sync_cnt_r <= sync_cnt_r;
                    end
                    if ((cnt_r == 3'd6) && (sync_cnt_r == SYNC_LAST)) begin
                        st_r <= ST_ACTIVE;
                    end else begin
                        st_r <= ST_SYNC;
                    end
                end
                ST_ACTIVE: begin
                    st_r <= ST_ACTIVE;
                end
                default: begin
                    st_r <= ST_SYNC;
                end
            endcase
        end
    end
`else
    // Without the sync phase the link is live straight out of reset
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            st_r <= ST_ACTIVE;
        end else begin
            st_r <= ST_ACTIVE;
        end
    end
`endif

endmodule

// File: doc/paralelo_serie_tx.md
# paralelo_serie_tx

Parallel-to-serial transmitter for the PHY. It accepts one 8-bit byte per 8 `clk_8f` cycles from the logic layer and shifts it out MSB first on a single serial line. When no valid byte is offered, it inserts the 0xBC comma as the idle symbol. It is the transmit-side counterpart of the PHY's serial-to-parallel receive path, and the receive path's comma detection locks onto its output.

## Interface
Parameters:
- `SYNC_BYTES`, 4: number of comma bytes sent after reset before the first data byte can be accepted. Must be ≥1. Used only with `PS_TX_SYNC_EN`.

Ports:
- `clk_8f` in 1: bit clock, 8× the byte rate. This is the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `data_in` in 8: byte to transmit. Sampled only on a ready edge.
- `valid_in` in 1: `data_in` holds a byte to send.
- `ready_out` out 1: byte slot open. The byte is taken at the rising edge that ends a cycle in which both `ready_out` and `valid_in` are high.
- `data_out` out 1: serial bit, equal to `shreg[7]`.
- `frame_out` out 1: high while the MSB of a byte is on `data_out`.
- `active_out` out 1: high while the byte being shifted out is data rather than comma.

## Operation
Internal state:
- 3-bit bit counter `cnt`.
- 8-bit shift register `shreg`.
- State register `st` with two states, SYNC and ACTIVE.
- Byte counter `sync_cnt`, wide enough for `SYNC_BYTES`.

Reset values, forced asynchronously while `reset`=0:
- `cnt`=0, `shreg`=0xBC, `st`=SYNC, `sync_cnt`=0, `active_out`=0.
- Resulting outputs: `data_out`=1, `frame_out`=1, `ready_out`=0.

Every rising edge:
- `cnt` increments and wraps 7→0.

Wrap edge (`cnt`==7):
- If `ready_out`&&`valid_in`: `shreg`←`data_in` and `active_out`←1.
- Otherwise: `shreg`←0xBC and `active_out`←0.

Any other edge:
- `shreg`←{`shreg[6:0]`,0}.

Combinational outputs:
- `frame_out` = (`cnt`==0).
- `ready_out` = (`cnt`==7) && (`st`==ACTIVE).

State machine:
- SYNC: `sync_cnt` increments on each wrap edge. `st` moves to ACTIVE so that the first `ready_out` pulse falls in the `cnt`==7 cycle of the SYNC_BYTES-th comma.
- ACTIVE: terminal state. Only reset leaves it.

Boundary conditions:
- `valid_in` high outside a ready cycle: ignored. `data_in` need only be stable during the ready cycle.
- `valid_in` low in a ready cycle: a comma is sent. This is not an error.
- Data byte equal to 0xBC: sent unchanged, with `active_out`=1.
- Back-to-back bytes: one byte per 8 cycles, with no gap bits.
- Reset asserted mid-byte: the byte in flight is discarded immediately. After release the block restarts with a full SYNC sequence, or the 1-comma start without the macro.

## Timing
- Cycle 0 is the first cycle after `reset` is released.
- The byte accepted at the edge ending cycle N drives its MSB on `data_out` in cycle N+1 and its LSB in cycle N+8.
- `frame_out` and `active_out` are high in cycle N+1. `active_out` stays constant for cycles N+1..N+8.
- `ready_out` pulses for one cycle every 8 cycles in ACTIVE, at cycles 8k+7.
- First `ready_out` pulse:
  - With `PS_TX_SYNC_EN`: cycle 8·`SYNC_BYTES`−1 (cycle 31 for the default).
  - Without `PS_TX_SYNC_EN`: cycle 7.

## Configuration
- `PS_TX_SYNC_EN` defined: the SYNC state is used. Exactly `SYNC_BYTES` commas are sent after reset regardless of `valid_in`, and `ready_out` is held low during that time.
- `PS_TX_SYNC_EN` undefined: `st` resets to ACTIVE and `sync_cnt` is not built. Exactly one comma (the reset contents of `shreg`) precedes the first data byte.

## Test plan
- Reset held, then released with `valid_in`=0 → `data_out` pattern 1,0,1,1,1,1,0,0 repeating. `frame_out` high every 8th cycle. `active_out`=0.
- `PS_TX_SYNC_EN`, `SYNC_BYTES`=4, `valid_in`=1 from cycle 0 → `ready_out` low through cycle 30 and high at cycle 31. 0x5A appears serially in cycles 32–39 as 0,1,0,1,1,0,1,0.
- Macro undefined, bytes 0xFF, 0x00, 0xA5 offered back to back → accepted at cycles 7, 15, 23. Serial output is contiguous with no idle bits. `active_out` is high for cycles 8–31.
- `valid_in` toggling 1,0,1 across three ready cycles with data 0x11/0x22/0x33 → output is 0x11, comma 0xBC (with `active_out`=0), 0x33. 0x22 is never sent.
- Data 0xBC sent → bits are identical to idle, but `active_out`=1 for those 8 cycles.
- Reset asserted at `cnt`=3 during byte 0x81 → outputs immediately read `data_out`=1, `frame_out`=1, `ready_out`=0, `active_out`=0. After release the full sync sequence repeats.
